fractcam_update_ctrl: RTL

- Sequences rule installation into the fractured LUTRAM TCAM (`frac_tcam`). Each write covers one 8-rule block.
- A requester hands over a whole block: 8 rules, each a value plus a don't-care mask, and a block index.
- The controller sweeps all 32 LUTRAM addresses. At each address it drives the per-address match bits on DI and the one-hot block write enable.
- It replaces the free-running `update_logic` between the key/rule source and `frac_tcam`, and runs on the TCAM write clock.

---
 rtl/fractcam_update_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fractcam_update_ctrl.sv
// Block-write sequencer for the fractured LUTRAM TCAM.
// Sweeps 32 LUTRAM addresses per accepted 8-rule block.
module fractcam_update_ctrl #(
  parameter int D = 512,
  parameter int W = 20,
  localparam int N = D / 8,
  localparam int SN = (N > 1) ? $clog2(N) : 1,
  localparam int RB = W * 8 / 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [SN-1:0]  req_block,
  input  logic [8*W-1:0] req_rules,
  input  logic [8*W-1:0] req_masks,
  output logic [W-1:0]   addr,
  output logic [N-1:0]   we,
  output logic [RB-1:0]  DI,
  output logic           busy,
  output logic           done,
  output logic           err
);
  localparam int C = W / 5;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_t;

  state_t         state, state_n;
  logic [4:0]     cnt, cnt_n;
  logic [SN-1:0]  blk, blk_n;
  logic [8*W-1:0] rules, rules_n;
  logic [8*W-1:0] masks, masks_n;
  logic           err_n;
  logic           in_range;
  logic [SN:0]    blk_wide;
  logic [RB-1:0]  di_n;
  logic           wr_n;

  assign blk_wide = {1'b0, req_block};
  assign in_range = blk_wide < (SN+1)'(N);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    blk_n   = blk;
    rules_n = rules;
    masks_n = masks;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          if (in_range) begin
            blk_n   = req_block;
            rules_n = req_rules;
            masks_n = req_masks;
            cnt_n   = 5'd0;
            state_n = WRITE;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      WRITE: begin
        cnt_n = cnt + 5'd1;
        if (cnt == 5'd31) state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Match bits are computed from next-state values so outputs land registered
  always_comb begin
    di_n = '0;
    for (int c = 0; c < C; c++) begin
      for (int r = 0; r < 8; r++) begin
        di_n[c*8+r] =
          ((cnt_n ^ rules_n[r*W+c*5 +: 5])
           & ~masks_n[r*W+c*5 +: 5]) == 5'd0;
      end
    end
  end

  assign wr_n = (state_n == WRITE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      blk   <= '0;
      rules <= '0;
      masks <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      blk   <= blk_n;
      rules <= rules_n;
      masks <= masks_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr      <= '0;
      we        <= '0;
      DI        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      addr      <= wr_n ? {C{cnt_n}} : '0;
      we        <= wr_n ? (N'(1) << blk_n) : '0;
      DI        <= wr_n ? di_n : '0;
      busy      <= wr_n;
      done      <= (state_n == DONE);
      err       <= err_n;
      req_ready <= (state_n == IDLE);
    end
  end

endmodule
